// File: rtl/mmul_pkg.sv
// Shared command codes, sequencer FSM states and address-map base helpers
// for the matrix-multiply request generator.
package mmul_pkg;

   localparam logic [3:0] CMD_IDLE    = 4'd0;
   localparam logic [3:0] CMD_READ8   = 4'd1;
   localparam logic [3:0] CMD_READ16  = 4'd2;
   localparam logic [3:0] CMD_WRITE32 = 4'd7;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_RD_A   = 4'd1,
      ST_WAIT_A = 4'd2,
      ST_RD_B   = 4'd3,
      ST_WAIT_B = 4'd4,
      ST_MAC    = 4'd5,
      ST_WR_HI  = 4'd6,
      ST_WR_LO  = 4'd7,
      ST_WAIT_W = 4'd8,
      ST_DONE   = 4'd9
   } state_t;

   localparam int unsigned A_BASE = 32'd0;

   function automatic int unsigned b_base(input int unsigned m, input int unsigned k);
      return m * k;
   endfunction

   function automatic int unsigned c_base(input int unsigned m, input int unsigned n,
                                          input int unsigned k);
      return m * k + 32'd2 * k * n;
   endfunction

endpackage

// File: rtl/mmul_addr_gen.sv
// Maps loop indices and the request state to a byte address in the A/B/C
// memory map, keeping the index multipliers out of the sequencer FSM.
module mmul_addr_gen
   import mmul_pkg::*;
#(
   parameter int M      = 64,
   parameter int N      = 60,
   parameter int K      = 32,
   parameter int ADDR_W = 19,
   parameter int YW     = 6,
   parameter int XW     = 6,
   parameter int KW     = 5
) (
   input  state_t            state,
   input  logic [YW-1:0]     y,
   input  logic [XW-1:0]     x,
   input  logic [KW-1:0]     k,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(A_BASE);
   localparam logic [ADDR_W-1:0] BASE_B = ADDR_W'(b_base(M, K));
   localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(c_base(M, N, K));
   localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(N);
   localparam logic [ADDR_W-1:0] K_A    = ADDR_W'(K);

   logic [ADDR_W-1:0] y_s;
   logic [ADDR_W-1:0] x_s;
   logic [ADDR_W-1:0] k_s;

   assign y_s = ADDR_W'(y);
   assign x_s = ADDR_W'(x);
   assign k_s = ADDR_W'(k);

   // Address of the request issued in the given state; other states park at zero.
   always_comb begin
      addr = {ADDR_W{1'b0}};
      case (state)
         ST_RD_A:  addr = BASE_A + y_s * K_A + k_s;
         ST_RD_B:  addr = BASE_B + ((k_s * N_A + x_s) << 2'd1);
         ST_WR_HI: addr = BASE_C + ((y_s * N_A + x_s) << 2'd2);
         ST_WR_LO: addr = BASE_C + ((y_s * N_A + x_s) << 2'd2);
         default:  addr = {ADDR_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/mmul_seq.sv
// Matrix-multiply sequencer: walks y/x/k like the software loop, issues the
// A/B reads and split C writes to the cache, and accumulates dot products.
module mmul_seq
   import mmul_pkg::*;
#(
   parameter int M      = 64,
   parameter int N      = 60,
   parameter int K      = 32,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [3:0]        req_cmd,
   output logic [ADDR_W-1:0] req_addr,
   output logic [15:0]       req_wdata,
   input  logic              rsp_valid,
   input  logic [15:0]       rsp_data
);

   localparam int YW = (M > 1) ? $clog2(M) : 1;
   localparam int XW = (N > 1) ? $clog2(N) : 1;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam logic [YW-1:0] Y_LAST = YW'(M - 1);
   localparam logic [XW-1:0] X_LAST = XW'(N - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);

   state_t            state_r, state_s;
   logic [YW-1:0]     y_r, y_s;
   logic [XW-1:0]     x_r, x_s;
   logic [KW-1:0]     k_r, k_s;
   logic [31:0]       acc_r, acc_s;
   logic [7:0]        a_r, a_s;
   logic [15:0]       b_r, b_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              valid_r, valid_s;
   logic [3:0]        cmd_r, cmd_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [15:0]       wdata_r, wdata_s;

   // Next state, loop counters and datapath updates.
   always_comb begin
      state_s = state_r;
      y_s     = y_r;
      x_s     = x_r;
      k_s     = k_r;
      acc_s   = acc_r;
      a_s     = a_r;
      b_s     = b_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_RD_A;
               y_s     = {YW{1'b0}};
               x_s     = {XW{1'b0}};
               k_s     = {KW{1'b0}};
               acc_s   = 32'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD_A: begin
            if (valid_r && req_ready) state_s = ST_WAIT_A;
            else                      state_s = ST_RD_A;
         end
         ST_WAIT_A: begin
            if (rsp_valid) begin
               a_s     = rsp_data[7:0];
               state_s = ST_RD_B;
            end else begin
               state_s = ST_WAIT_A;
            end
         end
         ST_RD_B: begin
            if (valid_r && req_ready) state_s = ST_WAIT_B;
            else                      state_s = ST_RD_B;
         end
         ST_WAIT_B: begin
            if (rsp_valid) begin
               b_s     = rsp_data;
               state_s = ST_MAC;
            end else begin
               state_s = ST_WAIT_B;
            end
         end
         ST_MAC: begin
            // 8x16 product fits in 24 bits; the accumulator wraps mod 2^32.
            acc_s = acc_r + {8'd0, ({16'd0, a_r} * {8'd0, b_r})};
            if (k_r != K_LAST) begin
               k_s     = k_r + KW'(1'b1);
               state_s = ST_RD_A;
            end else begin
               state_s = ST_WR_HI;
            end
         end
         ST_WR_HI: begin
            if (valid_r && req_ready) state_s = ST_WR_LO;
            else                      state_s = ST_WR_HI;
         end
         ST_WR_LO: begin
            if (valid_r && req_ready) state_s = ST_WAIT_W;
            else                      state_s = ST_WR_LO;
         end
         ST_WAIT_W: begin
            if (rsp_valid) begin
               acc_s = 32'd0;
               k_s   = {KW{1'b0}};
               if (x_r == X_LAST) begin
                  x_s = {XW{1'b0}};
                  if (y_r == Y_LAST) begin
                     state_s = ST_DONE;
                  end else begin
                     y_s     = y_r + YW'(1'b1);
                     state_s = ST_RD_A;
                  end
               end else begin
                  x_s     = x_r + XW'(1'b1);
                  state_s = ST_RD_A;
               end
            end else begin
               state_s = ST_WAIT_W;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   mmul_addr_gen #(
      .M      (M),
      .N      (N),
      .K      (K),
      .ADDR_W (ADDR_W),
      .YW     (YW),
      .XW     (XW),
      .KW     (KW)
   ) u_addr_gen (
      .state (state_s),
      .y     (y_s),
      .x     (x_s),
      .k     (k_s),
      .addr  (addr_s)
   );

   // Output values for the state being entered, so every output is a flop.
   always_comb begin
      busy_s  = 1'b1;
      done_s  = 1'b0;
      valid_s = 1'b0;
      cmd_s   = CMD_IDLE;
      wdata_s = 16'd0;
      case (state_s)
         ST_IDLE: busy_s = 1'b0;
         ST_RD_A: begin
            valid_s = 1'b1;
            cmd_s   = CMD_READ8;
         end
         ST_RD_B: begin
            valid_s = 1'b1;
            cmd_s   = CMD_READ16;
         end
         ST_WR_HI: begin
            valid_s = 1'b1;
            cmd_s   = CMD_WRITE32;
            wdata_s = acc_s[31:16];
         end
         ST_WR_LO: begin
            valid_s = 1'b1;
            cmd_s   = CMD_WRITE32;
            wdata_s = acc_s[15:0];
         end
         ST_DONE: begin
            busy_s = 1'b0;
            done_s = 1'b1;
         end
         default: busy_s = 1'b1;
      endcase
   end

   // State, counters, accumulator and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         y_r     <= {YW{1'b0}};
         x_r     <= {XW{1'b0}};
         k_r     <= {KW{1'b0}};
         acc_r   <= 32'd0;
         a_r     <= 8'd0;
         b_r     <= 16'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         valid_r <= 1'b0;
         cmd_r   <= CMD_IDLE;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= 16'd0;
      end else begin
         state_r <= state_s;
         y_r     <= y_s;
         x_r     <= x_s;
         k_r     <= k_s;
         acc_r   <= acc_s;
         a_r     <= a_s;
         b_r     <= b_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         valid_r <= valid_s;
         cmd_r   <= cmd_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign req_valid = valid_r;
   assign req_cmd   = cmd_r;
   assign req_addr  = addr_r;
   assign req_wdata = wdata_r;

endmodule

// File: tb/tb_mmul_seq.sv
// Bench for mmul_seq: a byte-addressed cache model with configurable
// back-pressure and latency, checked against a loop-level reference.
module tb_mmul_seq;

   localparam int M      = 3;
   localparam int N      = 4;
   localparam int K      = 5;
   localparam int AW     = 10;
   localparam int BB     = M * K;
   localparam int CB     = M * K + 2 * K * N;
   localparam int BUDGET = 20000;

   logic          clk;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_cmd;
   logic [AW-1:0] req_addr;
   logic [15:0]   req_wdata;
   logic          rsp_valid;
   logic [15:0]   rsp_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  mem   [1024];
   logic [7:0]  a_m   [M][K];
   logic [15:0] b_m   [K][N];
   logic [31:0] c_ref [M*N];
   logic [31:0] c_obs [M*N];
   logic [35:0] exp_q [$];

   mmul_seq #(.M(M), .N(N), .K(K), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_cmd   (req_cmd),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // kind 0: small sequential values, 1: all-ones extremes, 2: random
   task automatic load_mats(input int kind);
      for (int y = 0; y < M; y++)
         for (int k = 0; k < K; k++)
            a_m[y][k] = (kind == 0) ? 8'(y * K + k + 1) : (kind == 1) ? 8'hFF : 8'($urandom);
      for (int k = 0; k < K; k++)
         for (int x = 0; x < N; x++)
            b_m[k][x] = (kind == 0) ? 16'(k * N + x + 1) : (kind == 1) ? 16'hFFFF : 16'($urandom);
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      for (int y = 0; y < M; y++)
         for (int k = 0; k < K; k++) mem[y * K + k] = a_m[y][k];
      for (int k = 0; k < K; k++)
         for (int x = 0; x < N; x++) begin
            mem[BB + 2 * (k * N + x)]     = b_m[k][x][7:0];
            mem[BB + 2 * (k * N + x) + 1] = b_m[k][x][15:8];
         end
   endtask

   // mode 0: always ready, 1-cycle rsp; 1: ready every other cycle, 3-cycle rsp;
   // 2: random ready/latency with spurious rsp_valid and start pulses.
   task automatic run_pass(input int mode, input int abort_b);
      int iter, lat, due, n_r8, n_r16, n_w, n_done, mac_iter, ai, idx;
      bit pend, pend_r16, stall, wr_hi, abort_now;
      logic [15:0]   pend_data, pw;
      logic [31:0]   acc;
      logic [35:0]   e, o;
      logic [3:0]    pc;
      logic [AW-1:0] pa;

      exp_q.delete();
      for (int y = 0; y < M; y++)
         for (int x = 0; x < N; x++) begin
            acc = 32'd0;
            for (int k = 0; k < K; k++) begin
               exp_q.push_back({4'd1, 16'(y * K + k), 16'd0});
               exp_q.push_back({4'd2, 16'(BB + 2 * (k * N + x)), 16'd0});
               acc = acc + {24'd0, a_m[y][k]} * {16'd0, b_m[k][x]};
            end
            c_ref[y * N + x] = acc;
            exp_q.push_back({4'd7, 16'(CB + 4 * (y * N + x)), acc[31:16]});
            exp_q.push_back({4'd7, 16'(CB + 4 * (y * N + x)), acc[15:0]});
         end
      for (int i = 0; i < M * N; i++) c_obs[i] = 32'hFFFF_FFFF;
      n_r8 = 0; n_r16 = 0; n_w = 0; n_done = 0; mac_iter = -1; due = 0;
      pend = 1'b0; pend_r16 = 1'b0; stall = 1'b0; wr_hi = 1'b0; abort_now = 1'b0;
      pend_data = 16'd0; pc = 4'd0; pa = '0; pw = 16'd0; lat = 1;

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("first_req", {busy, req_valid, req_cmd, 16'(req_addr)}, {1'b1, 1'b1, 4'd1, 16'd0});
      iter = 1;
      while (n_done == 0 && iter < BUDGET) begin
         if (abort_now) begin
            reset = 1'b1;
            #1;
            check("outputs_in_reset", {busy, done, req_valid, req_cmd, 16'(req_addr), req_wdata}, 64'd0);
            rsp_valid = 1'b0; start = 1'b0; req_ready = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            return;
         end
         if (pend) check("valid_in_wait", req_valid, 1'b0);
         if (stall)
            check("stall_stable", {req_valid, req_cmd, 16'(req_addr), req_wdata}, {1'b1, pc, 16'(pa), pw});
         if (done) begin
            n_done++;
            check("busy_valid_at_done", {busy, req_valid}, 2'b00);
         end else begin
            check("busy_in_run", busy, 1'b1);
         end
         rsp_valid = 1'b0;
         rsp_data  = 16'($urandom);
         if (pend && iter == due) begin
            rsp_valid = 1'b1;
            rsp_data  = pend_data;
            pend      = 1'b0;
            if (pend_r16) mac_iter = iter + 1;
         end else if (mode == 2 && !pend && (req_valid || iter == mac_iter) &&
                      $urandom_range(0, 2) == 0) begin
            rsp_valid = 1'b1;
         end
         start = (mode == 2) && busy && ($urandom_range(0, 3) == 0);
         case (mode)
            0:       begin req_ready = 1'b1;               lat = 1; end
            1:       begin req_ready = ((iter % 2) == 1);  lat = 3; end
            default: begin req_ready = 1'($urandom);       lat = $urandom_range(1, 4); end
         endcase
         if (req_valid && req_ready) begin
            check("req_expected", 64'(exp_q.size() > 0), 64'd1);
            e  = (exp_q.size() > 0) ? exp_q.pop_front() : 36'd0;
            o  = {req_cmd, 16'(req_addr), req_wdata};
            if (e[35:32] != 4'd7) begin
               e[15:0] = 16'd0;
               o[15:0] = 16'd0;
            end
            check("req", o, e);
            ai = int'(req_addr);
            case (req_cmd)
               4'd1: begin
                  n_r8++;
                  pend = 1'b1; pend_r16 = 1'b0; due = iter + lat;
                  pend_data = {8'($urandom), mem[ai]};
               end
               4'd2: begin
                  n_r16++;
                  pend = 1'b1; pend_r16 = 1'b1; due = iter + lat;
                  pend_data = {mem[ai + 1], mem[ai]};
               end
               4'd7: begin
                  idx = (ai - CB) / 4;
                  if (!wr_hi) begin
                     if (idx >= 0 && idx < M * N) c_obs[idx][31:16] = req_wdata;
                     wr_hi = 1'b1;
                  end else begin
                     if (idx >= 0 && idx < M * N) c_obs[idx][15:0] = req_wdata;
                     wr_hi = 1'b0;
                     n_w++;
                     pend = 1'b1; pend_r16 = 1'b0; due = iter + lat;
                     pend_data = 16'($urandom);
                  end
               end
               default: n_w = n_w;
            endcase
            if (abort_b != 0 && req_cmd == 4'd2 && n_r16 == abort_b) abort_now = 1'b1;
         end
         stall = req_valid && !req_ready;
         pc = req_cmd; pa = req_addr; pw = req_wdata;
         @(posedge clk); #1;
         iter++;
      end
      start = 1'b0;
      rsp_valid = 1'b0;
      check("done_pulses", 64'(n_done), 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("quiet_after_done", {busy, done, req_valid}, 3'b000);
      end
      check("read8_count",  64'(n_r8),  64'(M * N * K));
      check("read16_count", 64'(n_r16), 64'(M * N * K));
      check("write_pairs",  64'(n_w),   64'(M * N));
      for (int i = 0; i < M * N; i++) check("c_value", c_obs[i], c_ref[i]);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {busy, done, req_valid, req_cmd, 16'(req_addr), req_wdata}, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_without_start", {busy, done, req_valid}, 3'b000);

      load_mats(0);
      run_pass(0, 0);
      run_pass(1, 0);

      load_mats(1);
      run_pass(0, 0);
      check("c_max", c_obs[0], 32'd83557125);

      load_mats(2);
      run_pass(1, 2);
      run_pass(1, 0);

      for (int r = 0; r < 3; r++) begin
         load_mats(2);
         run_pass(2, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
